// File: rtl/alu_cdb_unit_pkg.sv
// -----------------------------------------------------------------------------
// alu_cdb_unit_pkg
// Shared definitions for the ALU execution / CDB broadcast slice.
//   - Bus widths for OpBus, ROBBus and DataBus
//   - Boolean / enable constants
//   - Internal ALU opcode encoding (alu_op_e)
// No ports.
// -----------------------------------------------------------------------------
package alu_cdb_unit_pkg;

    localparam int OP_BUS_W   = 6;
    localparam int ROB_BUS_W  = 4;
    localparam int DATA_BUS_W = 32;

    localparam logic TRUE    = 1'b1;
    localparam logic FALSE   = 1'b0;
    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    // Encoding 0 and everything past OP_AND are not ALU operations; they
    // still produce a (zero) result so the ROB entry completes.
    typedef enum logic [OP_BUS_W-1:0] {
        OP_NOP   = 6'd0,
        OP_LUI   = 6'd1,
        OP_AUIPC = 6'd2,
        OP_JAL   = 6'd3,
        OP_JALR  = 6'd4,
        OP_BEQ   = 6'd5,
        OP_BNE   = 6'd6,
        OP_BLT   = 6'd7,
        OP_BGE   = 6'd8,
        OP_BLTU  = 6'd9,
        OP_BGEU  = 6'd10,
        OP_ADDI  = 6'd11,
        OP_SLTI  = 6'd12,
        OP_SLTIU = 6'd13,
        OP_XORI  = 6'd14,
        OP_ORI   = 6'd15,
        OP_ANDI  = 6'd16,
        OP_SLLI  = 6'd17,
        OP_SRLI  = 6'd18,
        OP_SRAI  = 6'd19,
        OP_ADD   = 6'd20,
        OP_SUB   = 6'd21,
        OP_SLL   = 6'd22,
        OP_SLT   = 6'd23,
        OP_SLTU  = 6'd24,
        OP_XOR   = 6'd25,
        OP_SRL   = 6'd26,
        OP_SRA   = 6'd27,
        OP_OR    = 6'd28,
        OP_AND   = 6'd29
    } alu_op_e;

endpackage

// File: rtl/alu_cdb_unit_if.sv
// -----------------------------------------------------------------------------
// alu_cdb_unit_if
// Bundles the RS->ALU issue bus and the ALU half of the CDB.
//   Issue:  ALU_S, ALU_Op, ALU_Vj, ALU_Vk, ALU_A, ALU_pc, ALU_Reorder, ALU_full
//   CDB:    CDB_ALU_req, CDB_ALU_gnt, CDB_ALU_S, CDB_ALU_Reorder,
//           CDB_ALU_Value, CDB_ALU_Jump, CDB_ALU_Target
// Modports: master = RS / arbiter side, slave = alu_cdb_unit.
// -----------------------------------------------------------------------------
interface alu_cdb_unit_if #(
    parameter int DATA_W = 32,
    parameter int ROB_W  = 4,
    parameter int OP_W   = 6
);
    logic              ALU_S;
    logic [OP_W-1:0]   ALU_Op;
    logic [DATA_W-1:0] ALU_Vj;
    logic [DATA_W-1:0] ALU_Vk;
    logic [DATA_W-1:0] ALU_A;
    logic [DATA_W-1:0] ALU_pc;
    logic [ROB_W-1:0]  ALU_Reorder;
    logic              ALU_full;

    logic              CDB_ALU_req;
    logic              CDB_ALU_gnt;
    logic              CDB_ALU_S;
    logic [ROB_W-1:0]  CDB_ALU_Reorder;
    logic [DATA_W-1:0] CDB_ALU_Value;
    logic              CDB_ALU_Jump;
    logic [DATA_W-1:0] CDB_ALU_Target;

    modport master (
        output ALU_S, ALU_Op, ALU_Vj, ALU_Vk, ALU_A, ALU_pc, ALU_Reorder,
        output CDB_ALU_gnt,
        input  ALU_full,
        input  CDB_ALU_req, CDB_ALU_S, CDB_ALU_Reorder, CDB_ALU_Value,
        input  CDB_ALU_Jump, CDB_ALU_Target
    );

    modport slave (
        input  ALU_S, ALU_Op, ALU_Vj, ALU_Vk, ALU_A, ALU_pc, ALU_Reorder,
        input  CDB_ALU_gnt,
        output ALU_full,
        output CDB_ALU_req, CDB_ALU_S, CDB_ALU_Reorder, CDB_ALU_Value,
        output CDB_ALU_Jump, CDB_ALU_Target
    );
endinterface

// File: rtl/alu_cdb_unit_alu_exec.sv
// -----------------------------------------------------------------------------
// alu_exec
// Purely combinational RV32I ALU: result value, branch/jump outcome and
// redirect target from one issued operation.
//   in  op      internal opcode (alu_op_e encoding)
//   in  vj, vk  source operands
//   in  a       immediate
//   in  pc      instruction pc
//   out value   rd value (0 for branches and unknown opcodes)
//   out jump    control transfer taken
//   out target  redirect pc (only meaningful for jumps/branches)
// -----------------------------------------------------------------------------
module alu_exec
    import alu_cdb_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OP_W   = 6
) (
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] vj,
    input  logic [DATA_W-1:0] vk,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] value,
    output logic              jump,
    output logic [DATA_W-1:0] target
);
    localparam int SH_W = $clog2(DATA_W);

    alu_op_e                  op_e;
    logic signed [DATA_W-1:0] vj_s;
    logic signed [DATA_W-1:0] vk_s;
    logic signed [DATA_W-1:0] a_s;
    logic [DATA_W-1:0]        br_target;
    logic [DATA_W-1:0]        jalr_sum;
    logic [DATA_W-1:0]        link;

    assign op_e      = alu_op_e'(op);
    assign vj_s      = vj;
    assign vk_s      = vk;
    assign a_s       = a;
    assign br_target = pc + a;
    assign jalr_sum  = vj + a;
    assign link      = pc + DATA_W'(4);

    always_comb begin
        value  = '0;
        jump   = 1'b0;
        target = '0;
        case (op_e)
            OP_LUI:   value = a;
            OP_AUIPC: value = pc + a;
            OP_JAL:   begin value = link; target = br_target; jump = 1'b1; end
            // JALR clears bit 0 of the computed address
            OP_JALR:  begin value = link; target = {jalr_sum[DATA_W-1:1], 1'b0}; jump = 1'b1; end
            OP_BEQ:   begin jump = (vj == vk);     target = br_target; end
            OP_BNE:   begin jump = (vj != vk);     target = br_target; end
            OP_BLT:   begin jump = (vj_s < vk_s);  target = br_target; end
            OP_BGE:   begin jump = (vj_s >= vk_s); target = br_target; end
            OP_BLTU:  begin jump = (vj < vk);      target = br_target; end
            OP_BGEU:  begin jump = (vj >= vk);     target = br_target; end
            OP_ADDI:  value = vj + a;
            OP_SLTI:  value = DATA_W'(vj_s < a_s);
            OP_SLTIU: value = DATA_W'(vj < a);
            OP_XORI:  value = vj ^ a;
            OP_ORI:   value = vj | a;
            OP_ANDI:  value = vj & a;
            OP_SLLI:  value = vj << a[SH_W-1:0];
            OP_SRLI:  value = vj >> a[SH_W-1:0];
            OP_SRAI:  value = vj_s >>> a[SH_W-1:0];
            OP_ADD:   value = vj + vk;
            OP_SUB:   value = vj - vk;
            OP_SLL:   value = vj << vk[SH_W-1:0];
            OP_SLT:   value = DATA_W'(vj_s < vk_s);
            OP_SLTU:  value = DATA_W'(vj < vk);
            OP_XOR:   value = vj ^ vk;
            OP_SRL:   value = vj >> vk[SH_W-1:0];
            OP_SRA:   value = vj_s >>> vk[SH_W-1:0];
            OP_OR:    value = vj | vk;
            OP_AND:   value = vj & vk;
            default:  ;
        endcase
    end
endmodule

// File: rtl/alu_cdb_unit.sv
// -----------------------------------------------------------------------------
// alu_cdb_unit
// Execution end of the RS->ALU issue interface. Computes each issued op
// through alu_exec, queues {tag, value, jump, target} in a DEPTH-entry FIFO
// and broadcasts the head entry on the ALU half of the CDB when granted.
//   in  clk, rst (async, active-high), rdy (low = freeze), clr (flush)
//   bus (alu_cdb_unit_if.slave): issue inputs, ALU_full, CDB request/grant
//       and broadcast fields
// Optional build macro ALU_CDB_BYPASS_EN: with an empty FIFO the freshly
// computed result is offered on the CDB in the issue cycle; if granted it is
// broadcast there and never enters the FIFO.
// -----------------------------------------------------------------------------
module alu_cdb_unit
    import alu_cdb_unit_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ROB_W  = 4,
    parameter int OP_W   = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rdy,
    input  logic         clr,
    alu_cdb_unit_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ROB_W-1:0]  tag_mem [DEPTH];
    logic [DATA_W-1:0] val_mem [DEPTH];
    logic              jmp_mem [DEPTH];
    logic [DATA_W-1:0] tgt_mem [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic [DATA_W-1:0] ex_value;
    logic              ex_jump;
    logic [DATA_W-1:0] ex_target;

    logic issue_ok;
    logic head_vld;
    logic byp;
    logic cdb_s;
    logic do_push;
    logic do_pop;

    alu_exec #(.DATA_W(DATA_W), .OP_W(OP_W)) u_exec (
        .op     (bus.ALU_Op),
        .vj     (bus.ALU_Vj),
        .vk     (bus.ALU_Vk),
        .a      (bus.ALU_A),
        .pc     (bus.ALU_pc),
        .value  (ex_value),
        .jump   (ex_jump),
        .target (ex_target)
    );

    assign issue_ok = rdy && !clr && bus.ALU_S;
    assign head_vld = (count != '0);

`ifdef ALU_CDB_BYPASS_EN
    assign byp = issue_ok && !head_vld;
`else
    assign byp = 1'b0;
`endif

    assign bus.CDB_ALU_req = rdy && !clr && (head_vld || byp);
    assign cdb_s           = bus.CDB_ALU_req && bus.CDB_ALU_gnt;
    assign bus.CDB_ALU_S   = cdb_s;
    assign bus.ALU_full    = (count >= CNT_W'(DEPTH - 2));

    // A granted bypass result is consumed directly; a full FIFO only accepts
    // an issue when the head leaves in the same cycle.
    assign do_pop  = cdb_s && !byp;
    assign do_push = issue_ok && !(byp && bus.CDB_ALU_gnt)
                     && ((count != CNT_W'(DEPTH)) || do_pop);

    // Fields are zeroed while nothing valid is offered so reset/flush leave
    // the CDB quiet rather than showing stale FIFO contents.
    always_comb begin
        bus.CDB_ALU_Reorder = '0;
        bus.CDB_ALU_Value   = '0;
        bus.CDB_ALU_Jump    = 1'b0;
        bus.CDB_ALU_Target  = '0;
        if (byp) begin
            bus.CDB_ALU_Reorder = bus.ALU_Reorder;
            bus.CDB_ALU_Value   = ex_value;
            bus.CDB_ALU_Jump    = ex_jump;
            bus.CDB_ALU_Target  = ex_target;
        end else if (head_vld) begin
            bus.CDB_ALU_Reorder = tag_mem[head];
            bus.CDB_ALU_Value   = val_mem[head];
            bus.CDB_ALU_Jump    = jmp_mem[head];
            bus.CDB_ALU_Target  = tgt_mem[head];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (clr) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) tail <= tail + 1'b1;
            if (do_pop)  head <= head + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Payload storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            tag_mem[tail] <= bus.ALU_Reorder;
            val_mem[tail] <= ex_value;
            jmp_mem[tail] <= ex_jump;
            tgt_mem[tail] <= ex_target;
        end
    end
endmodule

// File: tb/tb_alu_cdb_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_cdb_unit
// Self-checking bench for alu_cdb_unit (default build, DEPTH=4). Expected
// broadcasts are queued when an op is issued and popped by a negedge monitor
// whenever the DUT broadcasts; directed checks cover reset, back-pressure,
// overflow, flush, async reset and freeze.
// -----------------------------------------------------------------------------
module tb_alu_cdb_unit;
    import alu_cdb_unit_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic rdy;
    logic clr;

    always #5 clk = ~clk;

    alu_cdb_unit_if #(.DATA_W(32), .ROB_W(4), .OP_W(6)) bus ();

    alu_cdb_unit #(.DEPTH(4), .DATA_W(32), .ROB_W(4), .OP_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .clr (clr),
        .bus (bus)
    );

    typedef struct {
        logic [3:0]  tag;
        logic [31:0] val;
        logic        jmp;
        logic [31:0] tgt;
        bit          chk_tgt;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_bcast  = 0;
    int   bc0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Scoreboard monitor: every broadcast must match the oldest expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && bus.CDB_ALU_S === 1'b1) begin
            n_bcast++;
            if (sb.size() == 0) begin
                check("unexpected_bcast", 64'(bus.CDB_ALU_S), 64'd0);
            end else begin
                e = sb.pop_front();
                check("sb_tag",   64'(bus.CDB_ALU_Reorder), 64'(e.tag));
                check("sb_value", 64'(bus.CDB_ALU_Value),   64'(e.val));
                check("sb_jump",  64'(bus.CDB_ALU_Jump),    64'(e.jmp));
                if (e.chk_tgt) check("sb_target", 64'(bus.CDB_ALU_Target), 64'(e.tgt));
            end
        end
    end

    task automatic issue(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                         input logic [31:0] a, input logic [31:0] pc, input logic [3:0] tag,
                         input logic [31:0] ev, input logic ej, input logic [31:0] et,
                         input bit ct, input bit expect_push);
        bus.ALU_S       = 1'b1;
        bus.ALU_Op      = op;
        bus.ALU_Vj      = vj;
        bus.ALU_Vk      = vk;
        bus.ALU_A       = a;
        bus.ALU_pc      = pc;
        bus.ALU_Reorder = tag;
        if (expect_push) sb.push_back('{tag, ev, ej, et, ct});
        @(posedge clk);
        #1;
        bus.ALU_S = 1'b0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string pfx);
        check({pfx, "_req"},    64'(bus.CDB_ALU_req),     64'd0);
        check({pfx, "_S"},      64'(bus.CDB_ALU_S),       64'd0);
        check({pfx, "_full"},   64'(bus.ALU_full),        64'd0);
        check({pfx, "_tag"},    64'(bus.CDB_ALU_Reorder), 64'd0);
        check({pfx, "_value"},  64'(bus.CDB_ALU_Value),   64'd0);
        check({pfx, "_jump"},   64'(bus.CDB_ALU_Jump),    64'd0);
        check({pfx, "_target"}, 64'(bus.CDB_ALU_Target),  64'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rdy = 1'b1; clr = 1'b0;
        bus.ALU_S = 1'b0; bus.ALU_Op = '0; bus.ALU_Vj = '0; bus.ALU_Vk = '0;
        bus.ALU_A = '0; bus.ALU_pc = '0; bus.ALU_Reorder = '0; bus.CDB_ALU_gnt = 1'b0;

        // Reset state
        #2;
        check_quiet("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        bus.CDB_ALU_gnt = 1'b1;

        // ADD: broadcast exactly one cycle after issue, then idle
        issue(OP_ADD, 32'd5, 32'd7, 32'd0, 32'd0, 4'd3, 32'd12, 1'b0, 32'd0, 1'b0, 1'b1);
        @(negedge clk);
        check("add_S",     64'(bus.CDB_ALU_S),       64'd1);
        check("add_tag",   64'(bus.CDB_ALU_Reorder), 64'd3);
        check("add_value", 64'(bus.CDB_ALU_Value),   64'd12);
        @(negedge clk);
        check("add_S_after", 64'(bus.CDB_ALU_S), 64'd0);
        @(posedge clk); #1;

        // Operation mix, back to back with grant held
        issue(OP_BLT,   32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 4'd1, 32'd0, 1'b1, 32'h120, 1'b1, 1'b1);
        issue(OP_BLTU,  32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 4'd2, 32'd0, 1'b0, 32'h120, 1'b1, 1'b1);
        issue(OP_JALR,  32'h1003, 32'd0, 32'd4, 32'h40, 4'd4, 32'h44, 1'b1, 32'h1006, 1'b1, 1'b1);
        issue(OP_JAL,   32'd0, 32'd0, 32'h10, 32'h200, 4'd5, 32'h204, 1'b1, 32'h210, 1'b1, 1'b1);
        issue(OP_BEQ,   32'd3, 32'd3, 32'h8, 32'h300, 4'd6, 32'd0, 1'b1, 32'h308, 1'b1, 1'b1);
        issue(OP_BGE,   32'hFFFF_FFFF, 32'd1, 32'h8, 32'h300, 4'd7, 32'd0, 1'b0, 32'h308, 1'b1, 1'b1);
        issue(OP_LUI,   32'd0, 32'd0, 32'h1234_5000, 32'd0, 4'd8, 32'h1234_5000, 1'b0, 32'd0, 1'b0, 1'b1);
        issue(OP_AUIPC, 32'd0, 32'd0, 32'h2000, 32'h1000, 4'd9, 32'h3000, 1'b0, 32'd0, 1'b0, 1'b1);
        issue(OP_SUB,   32'd5, 32'd7, 32'd0, 32'd0, 4'd10, 32'hFFFF_FFFE, 1'b0, 32'd0, 1'b0, 1'b1);
        issue(OP_SRAI,  32'h8000_0000, 32'd0, 32'h404, 32'd0, 4'd11, 32'hF800_0000, 1'b0, 32'd0, 1'b0, 1'b1);
        issue(OP_SLTIU, 32'd1, 32'd0, 32'hFFFF_FFFF, 32'd0, 4'd12, 32'd1, 1'b0, 32'd0, 1'b0, 1'b1);
        issue(OP_SLTI,  32'd1, 32'd0, 32'hFFFF_FFFF, 32'd0, 4'd13, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);
        issue(OP_SRL,   32'h8000_0000, 32'h21, 32'd0, 32'd0, 4'd14, 32'h4000_0000, 1'b0, 32'd0, 1'b0, 1'b1);
        issue(OP_ADD,   32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 4'd15, 32'd1, 1'b0, 32'd0, 1'b0, 1'b1);
        issue(6'h3F,    32'd5, 32'd5, 32'd9, 32'h80, 4'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);
        cyc(2);

        // Back-pressure: ALU_full asserts at two queued entries
        bus.CDB_ALU_gnt = 1'b0;
        issue(OP_ADDI, 32'd10, 32'd0, 32'd1, 32'd0, 4'd1, 32'd11, 1'b0, 32'd0, 1'b0, 1'b1);
        check("bp_full_1", 64'(bus.ALU_full),    64'd0);
        check("bp_req_1",  64'(bus.CDB_ALU_req), 64'd1);
        issue(OP_XOR, 32'hF0, 32'hFF, 32'd0, 32'd0, 4'd2, 32'h0F, 1'b0, 32'd0, 1'b0, 1'b1);
        check("bp_full_2", 64'(bus.ALU_full),  64'd1);
        check("bp_S_nogn", 64'(bus.CDB_ALU_S), 64'd0);
        bus.CDB_ALU_gnt = 1'b1;
        @(negedge clk);
        check("bp_first_S",   64'(bus.CDB_ALU_S),       64'd1);
        check("bp_first_tag", 64'(bus.CDB_ALU_Reorder), 64'd1);
        @(negedge clk);
        check("bp_second_S",   64'(bus.CDB_ALU_S),       64'd1);
        check("bp_second_tag", 64'(bus.CDB_ALU_Reorder), 64'd2);
        @(negedge clk);
        check("bp_drained_S", 64'(bus.CDB_ALU_S), 64'd0);
        @(posedge clk); #1;

        // Overflow: fifth issue into a full FIFO is dropped
        bus.CDB_ALU_gnt = 1'b0;
        for (int i = 1; i <= 4; i++)
            issue(OP_ORI, 32'h100, 32'd0, 32'(i), 32'd0, 4'(i), 32'h100 | 32'(i), 1'b0, 32'd0, 1'b0, 1'b1);
        issue(OP_ORI, 32'h100, 32'd0, 32'd5, 32'd0, 4'd5, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        check("ovf_full", 64'(bus.ALU_full), 64'd1);
        bc0 = n_bcast;
        bus.CDB_ALU_gnt = 1'b1;
        cyc(6);
        check("ovf_bcasts", 64'(n_bcast - bc0), 64'd4);

        // Flush with three queued entries and a same-cycle issue
        bus.CDB_ALU_gnt = 1'b0;
        for (int i = 1; i <= 3; i++)
            issue(OP_ANDI, 32'hFF, 32'd0, 32'(i), 32'd0, 4'(i), 32'(i), 1'b0, 32'd0, 1'b0, 1'b1);
        bc0 = n_bcast;
        clr = 1'b1;
        bus.CDB_ALU_gnt = 1'b1;
        bus.ALU_S = 1'b1; bus.ALU_Op = OP_ADD; bus.ALU_Reorder = 4'd9;
        #1;
        check("clr_req_comb", 64'(bus.CDB_ALU_req), 64'd0);
        check("clr_S_comb",   64'(bus.CDB_ALU_S),   64'd0);
        @(posedge clk); #1;
        clr = 1'b0;
        bus.ALU_S = 1'b0;
        sb.delete();
        check("clr_req_after",  64'(bus.CDB_ALU_req), 64'd0);
        check("clr_full_after", 64'(bus.ALU_full),    64'd0);
        cyc(3);
        check("clr_no_bcast", 64'(n_bcast - bc0), 64'd0);

        // Asynchronous reset mid-queue
        bus.CDB_ALU_gnt = 1'b0;
        issue(OP_ADD, 32'd1, 32'd1, 32'd0, 32'd0, 4'd6, 32'd2, 1'b0, 32'd0, 1'b0, 1'b1);
        issue(OP_JAL, 32'd0, 32'd0, 32'h10, 32'h20, 4'd7, 32'h24, 1'b1, 32'h30, 1'b1, 1'b1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_quiet("arst");
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        check("arst_req_after", 64'(bus.CDB_ALU_req), 64'd0);

        // Freeze: entry held for three cycles, broadcast once rdy returns
        issue(OP_ADD, 32'd1, 32'd2, 32'd0, 32'd0, 4'd6, 32'd3, 1'b0, 32'd0, 1'b0, 1'b1);
        rdy = 1'b0;
        bus.CDB_ALU_gnt = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("frz_S",   64'(bus.CDB_ALU_S),   64'd0);
            check("frz_req", 64'(bus.CDB_ALU_req), 64'd0);
        end
        @(posedge clk); #1;
        rdy = 1'b1;
        @(negedge clk);
        check("frz_resume_S",     64'(bus.CDB_ALU_S),     64'd1);
        check("frz_resume_value", 64'(bus.CDB_ALU_Value), 64'd3);
        cyc(3);

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
